riscv_csr_dbg_initiator: RTL and testbench

Initiator side of the CSR register interface (csr_access/csr_addr/csr_wdata/csr_op/csr_rdata). Converts single-beat debug-bus CSR requests into CSR accesses. Before each access it halts the core pipeline so that pipeline CSR instructions cannot collide. Sits between the debug unit and the CSR register file, muxed onto the CSR port while the core is halted.

---
 rtl/riscv_defines.sv | 47 ++++
 rtl/riscv_csr_dbg_initiator.sv | 160 ++++++++++++++++
 tb/tb_riscv_csr_dbg_initiator.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// riscv_defines : shared CSR op encodings, debug-visible CSR map and legality.
// Revision: 1.0
// ============================================================================
package riscv_defines;

   localparam logic [1:0] CSR_OP_NONE  = 2'b00;
   localparam logic [1:0] CSR_OP_WRITE = 2'b01;
   localparam logic [1:0] CSR_OP_SET   = 2'b10;
   localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_RO_F00    = 12'hF00;
   localparam logic [11:0] CSR_RO_F01    = 12'hF01;
   localparam logic [11:0] CSR_RO_F10    = 12'hF10;
   localparam logic [11:0] CSR_DCSR      = 12'h7B0;
   localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
   localparam logic [11:0] CSR_DBG_B4    = 12'h7B4;
   localparam logic [11:0] CSR_DBG_B6    = 12'h7B6;
   localparam logic [11:0] CSR_DBG_C0    = 12'h7C0;
   localparam logic [11:0] CSR_TSELECT   = 12'h7A0;
   localparam logic [11:0] CSR_TDATA1    = 12'h7A1;
   localparam logic [11:0] CSR_HWLP_LO   = 12'h780;
   localparam logic [11:0] CSR_HWLP_HI   = 12'h79F;
   localparam logic [11:0] CSR_TPR       = 12'h700;
   localparam logic [11:0] CSR_TCR       = 12'h701;

   function automatic logic csr_dbg_legal(input logic [11:0] addr,
                                          input logic [1:0]  op,
                                          input logic        dift_en);
      logic impl;
      logic ro;
      ro   = (addr == CSR_RO_F00) || (addr == CSR_RO_F01) || (addr == CSR_RO_F10);
      impl = (addr inside {CSR_MSTATUS, CSR_MEPC, CSR_MCAUSE,
                           CSR_RO_F00, CSR_RO_F01, CSR_RO_F10,
                           [CSR_DCSR:CSR_DSCRATCH0], [CSR_DBG_B4:CSR_DBG_B6],
                           CSR_DBG_C0, CSR_TSELECT, CSR_TDATA1,
                           [CSR_HWLP_LO:CSR_HWLP_HI]})
             || (dift_en && ((addr == CSR_TPR) || (addr == CSR_TCR)));
      return impl && !(ro && (op != CSR_OP_NONE));
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_csr_dbg_initiator.sv
`default_nettype none
// ============================================================================
// riscv_csr_dbg_initiator : turns debug-bus CSR requests into halted-core CSR
// accesses, keeping the halt briefly after each response for back-to-back use.
// Revision: 1.0
// ============================================================================
module riscv_csr_dbg_initiator
   import riscv_defines::*;
#(
   parameter int HALT_TIMEOUT = 64,
   parameter int HOLD_CYCLES  = 8,
   parameter bit DIFT_EN      = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dbg_req_i,
   input  logic [1:0]  dbg_op_i,
   input  logic [11:0] dbg_addr_i,
   input  logic [31:0] dbg_wdata_i,
   output logic        dbg_gnt_o,
   output logic        dbg_rvalid_o,
   output logic [31:0] dbg_rdata_o,
   output logic        dbg_err_o,
   output logic        core_halt_req_o,
   input  logic        core_halted_i,
   output logic        csr_access_o,
   output logic [11:0] csr_addr_o,
   output logic [31:0] csr_wdata_o,
   output logic [1:0]  csr_op_o,
   input  logic [31:0] csr_rdata_i
);

   typedef enum logic [2:0] {S_IDLE, S_HALT, S_ACCESS, S_RESP, S_HOLD} state_e;

   localparam int TO_W   = $clog2(HALT_TIMEOUT + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int CNT_W  = (TO_W > HOLD_W) ? TO_W : HOLD_W;
   localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(HALT_TIMEOUT);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [1:0]        op_q, op_d;
   logic [11:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              halt_q, halt_d;
   logic              gnt, rvalid, access, req_legal;

   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign req_legal = csr_dbg_legal(dbg_addr_i, dbg_op_i, DIFT_EN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      halt_d  = halt_q;
      gnt     = 1'b0;
      rvalid  = 1'b0;
      access  = 1'b0;
      case (state_q)
         S_IDLE, S_HOLD: begin
            if (dbg_req_i) begin
               gnt     = 1'b1;
               op_d    = dbg_op_i;
               addr_d  = dbg_addr_i;
               wdata_d = dbg_wdata_i;
               if (!req_legal) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else if (state_q == S_HOLD) begin
                  // Core is already known halted: the halt was never released.
                  state_d = S_ACCESS;
               end else begin
                  state_d = S_HALT;
                  halt_d  = 1'b1;
                  cnt_d   = '0;
               end
            end else if (state_q == S_HOLD) begin
               if (cnt_inc == HOLD_LIM) begin
                  state_d = S_IDLE;
                  halt_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_HALT: begin
            if (core_halted_i) begin
               state_d = S_ACCESS;
            end else if (cnt_inc == TO_LIM) begin
               state_d = S_RESP;
               err_d   = 1'b1;
               rdata_d = '0;
               halt_d  = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_ACCESS: begin
            access  = 1'b1;
            rdata_d = csr_rdata_i;
            err_d   = 1'b0;
            state_d = S_RESP;
         end
         S_RESP: begin
            rvalid = 1'b1;
            if (!err_q && (HOLD_CYCLES > 0)) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
               halt_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= CSR_OP_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         halt_q  <= halt_d;
      end
   end

   // CSR port is parked at zero outside the access cycle so the core can share it.
   assign dbg_gnt_o       = gnt & ~rst;
   assign dbg_rvalid_o    = rvalid;
   assign dbg_rdata_o     = rvalid ? rdata_q : 32'h0;
   assign dbg_err_o       = rvalid & err_q;
   assign core_halt_req_o = halt_q;
   assign csr_access_o    = access;
   assign csr_addr_o      = access ? addr_q  : 12'h0;
   assign csr_wdata_o     = access ? wdata_q : 32'h0;
   assign csr_op_o        = access ? op_q    : CSR_OP_NONE;

endmodule
`default_nettype wire

// File: tb/tb_riscv_csr_dbg_initiator.sv
`default_nettype none
// ============================================================================
// tb_riscv_csr_dbg_initiator : directed self-checking bench for the CSR debug
// initiator, with a small core-halt and CSR register-file model.
// Revision: 1.0
// ============================================================================
module tb_riscv_csr_dbg_initiator;
   import riscv_defines::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        dbg_req, dbg_req_b;
   logic [1:0]  dbg_op;
   logic [11:0] dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_gnt, dbg_rvalid, dbg_err, halt_req, halted;
   logic [31:0] dbg_rdata;
   logic        csr_access;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, csr_rdata;
   logic [1:0]  csr_op;

   logic        gnt_b, rvalid_b, err_b, halt_b, access_b;
   logic [31:0] rdata_b, wdata_b;
   logic [11:0] addr_b;
   logic [1:0]  op_b;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   riscv_csr_dbg_initiator #(.HALT_TIMEOUT(4), .HOLD_CYCLES(8), .DIFT_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .dbg_req_i(dbg_req), .dbg_op_i(dbg_op), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
      .core_halt_req_o(halt_req), .core_halted_i(halted),
      .csr_access_o(csr_access), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
      .csr_op_o(csr_op), .csr_rdata_i(csr_rdata)
   );

   riscv_csr_dbg_initiator #(.HALT_TIMEOUT(4), .HOLD_CYCLES(8), .DIFT_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .dbg_req_i(dbg_req_b), .dbg_op_i(dbg_op), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_gnt_o(gnt_b), .dbg_rvalid_o(rvalid_b), .dbg_rdata_o(rdata_b), .dbg_err_o(err_b),
      .core_halt_req_o(halt_b), .core_halted_i(1'b0),
      .csr_access_o(access_b), .csr_addr_o(addr_b), .csr_wdata_o(wdata_b),
      .csr_op_o(op_b), .csr_rdata_i(32'h0)
   );

   // Core model: reports halted two cycles after the halt request, unless stuck.
   logic [1:0] hist = 2'b00;
   logic       stuck = 1'b0;
   always @(posedge clk) hist <= {hist[0], halt_req};
   assign halted = hist[1] & halt_req & ~stuck;

   logic [31:0] mstatus_m = 32'h6;
   logic [31:0] tcr_m     = 32'hABCD_0001;

   function automatic logic [31:0] apply(input logic [1:0] op, input logic [31:0] v, input logic [31:0] w);
      case (op)
         CSR_OP_WRITE: return w;
         CSR_OP_SET:   return v | w;
         CSR_OP_CLEAR: return v & ~w;
         default:      return v;
      endcase
   endfunction

   always_comb begin
      csr_rdata = 32'h0;
      case (csr_addr)
         12'h341: csr_rdata = 32'h0000_1234;
         12'h342: csr_rdata = 32'h0000_0055;
         12'h300: csr_rdata = mstatus_m;
         12'h701: csr_rdata = tcr_m;
         default: csr_rdata = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (csr_access && !rst) begin
         if (csr_addr == 12'h300) mstatus_m <= apply(csr_op, mstatus_m, csr_wdata);
         if (csr_addr == 12'h701) tcr_m     <= apply(csr_op, tcr_m, csr_wdata);
      end
   end

   int          acc_cnt = 0;
   int          rv_cnt  = 0;
   int          drops   = 0;
   logic        track   = 1'b0;
   logic [1:0]  last_op = 2'b00;
   logic [31:0] last_wdata = 32'h0;
   always @(negedge clk) begin
      if (csr_access) begin
         acc_cnt++;
         last_op    = csr_op;
         last_wdata = csr_wdata;
      end
      if (dbg_rvalid) rv_cnt++;
      if (track && !halt_req) drops++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
      @(posedge clk); #1;
      dbg_req = 1'b1; dbg_op = op; dbg_addr = addr; dbg_wdata = wd;
      @(negedge clk);
      chk("gnt", dbg_gnt, 1);
      @(posedge clk); #1;
      dbg_req = 1'b0;
   endtask

   task automatic wait_rv(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dbg_rvalid && n < 20);
      chk("rvalid_seen", dbg_rvalid, 1);
   endtask

   initial begin
      int n;
      int a0, a1, r0;
      rst = 1'b1; dbg_req = 1'b0; dbg_req_b = 1'b0;
      dbg_op = CSR_OP_NONE; dbg_addr = '0; dbg_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_gnt", dbg_gnt, 0);
      chk("rst_rvalid", dbg_rvalid, 0);
      chk("rst_halt", halt_req, 0);
      chk("rst_access", csr_access, 0);
      chk("rst_op", csr_op, CSR_OP_NONE);

      // Read mepc from IDLE, halted two cycles after the halt request.
      issue(CSR_OP_NONE, 12'h341, 32'h0);
      wait_rv(n);
      chk("rd341_latency", n, 5);
      chk("rd341_rdata", dbg_rdata, 32'h1234);
      chk("rd341_err", dbg_err, 0);
      chk("rd341_acc_cnt", acc_cnt, 1);
      chk("rd341_op", last_op, CSR_OP_NONE);
      repeat (12) @(negedge clk);
      chk("hold_expired_halt", halt_req, 0);

      // SET mstatus then read it back inside the hold window.
      issue(CSR_OP_SET, 12'h300, 32'h1);
      wait_rv(n);
      chk("set300_latency", n, 5);
      chk("set300_rdata", dbg_rdata, 32'h6);
      chk("set300_op", last_op, CSR_OP_SET);
      track = 1'b1;
      issue(CSR_OP_NONE, 12'h300, 32'h0);
      wait_rv(n);
      chk("hold_rd_latency", n, 2);
      chk("hold_rd_rdata", dbg_rdata, 32'h7);
      track = 1'b0;
      chk("hold_no_halt_drop", drops, 0);
      chk("hold_acc_cnt", acc_cnt, 3);
      repeat (12) @(negedge clk);
      chk("hold2_expired_halt", halt_req, 0);

      // Write to a read-only CSR.
      a0 = acc_cnt;
      issue(CSR_OP_WRITE, 12'hF10, 32'hFF);
      wait_rv(n);
      chk("ro_latency", n, 1);
      chk("ro_err", dbg_err, 1);
      chk("ro_rdata", dbg_rdata, 0);
      chk("ro_no_halt", halt_req, 0);
      chk("ro_no_access", acc_cnt, a0);

      // Halt timeout.
      stuck = 1'b1;
      issue(CSR_OP_NONE, 12'h341, 32'h0);
      wait_rv(n);
      chk("to_latency", n, 5);
      chk("to_err", dbg_err, 1);
      chk("to_rdata", dbg_rdata, 0);
      chk("to_halt_dropped", halt_req, 0);
      chk("to_no_access", acc_cnt, a0);
      stuck = 1'b0;
      repeat (4) @(negedge clk);

      // TPR illegal when DIFT is disabled.
      @(posedge clk); #1;
      dbg_req_b = 1'b1; dbg_op = CSR_OP_NONE; dbg_addr = 12'h700;
      @(negedge clk);
      chk("dift0_gnt", gnt_b, 1);
      @(posedge clk); #1;
      dbg_req_b = 1'b0;
      @(negedge clk);
      chk("dift0_rvalid", rvalid_b, 1);
      chk("dift0_err", err_b, 1);

      // TCR write with DIFT enabled, then a read landing on the last hold cycle.
      issue(CSR_OP_WRITE, 12'h701, 32'h0034_1800);
      wait_rv(n);
      chk("tcr_latency", n, 5);
      chk("tcr_rdata_old", dbg_rdata, 32'hABCD_0001);
      chk("tcr_err", dbg_err, 0);
      chk("tcr_op", last_op, CSR_OP_WRITE);
      chk("tcr_wdata", last_wdata, 32'h0034_1800);
      track = 1'b1;
      repeat (7) @(posedge clk);
      issue(CSR_OP_NONE, 12'h701, 32'h0);
      wait_rv(n);
      chk("expiry_req_latency", n, 2);
      chk("expiry_req_rdata", dbg_rdata, 32'h0034_1800);
      track = 1'b0;
      chk("expiry_no_halt_drop", drops, 0);
      repeat (12) @(negedge clk);

      // Reset in the ACCESS cycle.
      issue(CSR_OP_NONE, 12'h342, 32'h0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!csr_access && n < 20);
      chk("rst_mid_access_seen", csr_access, 1);
      r0 = rv_cnt;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_gnt", dbg_gnt, 0);
      chk("rstmid_rvalid", dbg_rvalid, 0);
      chk("rstmid_rdata", dbg_rdata, 0);
      chk("rstmid_err", dbg_err, 0);
      chk("rstmid_halt", halt_req, 0);
      chk("rstmid_access", csr_access, 0);
      chk("rstmid_addr", csr_addr, 0);
      chk("rstmid_op", csr_op, CSR_OP_NONE);
      a1 = acc_cnt;
      repeat (10) @(negedge clk);
      chk("rstmid_no_rvalid", rv_cnt, r0);
      chk("rstmid_no_access", acc_cnt, a1);

      // Back in IDLE: an unimplemented address answers with err next cycle.
      issue(CSR_OP_NONE, 12'h123, 32'h0);
      wait_rv(n);
      chk("illegal_latency", n, 1);
      chk("illegal_err", dbg_err, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
